// File: rtl/cache_controller_if.sv
// -----------------------------------------------------------------------------
// cache_controller_if
// Bundles the MEM-stage request/response signals and the SRAM-controller
// request/response signals seen by cache_controller.
//
// Signals:
//   MEM_R_EN, MEM_W_EN  load / store request from the MEM stage
//   address, wdata      byte address (word aligned) and store data
//   rdata, ready        load data and completion (ready low = freeze pipeline)
//   sram_rd_en/wr_en    read / write request to the SRAM controller
//   sram_address/wdata  copies of address / wdata towards the SRAM controller
//   sram_rdata          SRAM read data, valid while sram_ready is high
//   sram_ready          one-cycle completion pulse from the SRAM controller
//   hit_count/miss_count  statistics, present only with CACHE_STATS_EN
//
// Modports:
//   slave  - the cache controller
//   master - the environment (MEM stage + SRAM controller side)
//
// Optional feature macro: CACHE_STATS_EN
// -----------------------------------------------------------------------------
interface cache_controller_if;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic        sram_rd_en;
   logic        sram_wr_en;
   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic [31:0] sram_rdata;
   logic        sram_ready;
`ifdef CACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   modport slave (
      input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
      output rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata,
      output hit_count, miss_count
   );

   modport master (
      output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
      input  rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata,
      input  hit_count, miss_count
   );
`else
   modport slave (
      input  MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
      output rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
   );

   modport master (
      output MEM_R_EN, MEM_W_EN, address, wdata, sram_rdata, sram_ready,
      input  rdata, ready, sram_rd_en, sram_wr_en, sram_address, sram_wdata
   );
`endif
endinterface

// File: rtl/cache_controller.sv
// -----------------------------------------------------------------------------
// cache_controller
// 2-way set-associative, write-through, no-write-allocate data cache placed
// between the MEM stage and the SRAM controller. Read hits complete in the
// request cycle; read misses and all writes go to the SRAM controller while
// `ready` is held low to freeze the pipeline.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   bus        cache_controller_if.slave (MEM-stage and SRAM-controller signals)
//   state_dbg  current FSM state: 0 = IDLE, 1 = RMISS, 2 = WRITE
//
// Handshake: a request is accepted while MEM_R_EN/MEM_W_EN is high in IDLE.
// `ready` high in a cycle means the request presented in that cycle is done
// (and rdata is valid for loads). While ready is low the MEM stage keeps
// address/wdata stable. The SRAM side sees sram_rd_en/sram_wr_en held high
// until the single-cycle sram_ready pulse; a pulse outside an access is
// ignored.
//
// Optional feature macro: CACHE_STATS_EN (adds hit_count / miss_count).
// -----------------------------------------------------------------------------
module cache_controller #(
   parameter int INDEX_W = 6,
   parameter int TAG_W   = 11
) (
   input  logic               clk,
   input  logic               rst,
   cache_controller_if.slave  bus,
   output logic [1:0]         state_dbg
);

   localparam int SETS = 1 << INDEX_W;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RMISS = 2'd1,
      WRITE = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Per-set bookkeeping (cleared on reset).
   logic [SETS-1:0] valid0;
   logic [SETS-1:0] valid1;
   logic [SETS-1:0] lru;      // 0: way0 is the victim, 1: way1 is the victim

   // Tag and data arrays (not cleared; guarded by the valid bits).
   logic [TAG_W-1:0] tag0_mem  [SETS];
   logic [TAG_W-1:0] tag1_mem  [SETS];
   logic [31:0]      data0_mem [SETS];
   logic [31:0]      data1_mem [SETS];

   // Address decode.
   logic [INDEX_W-1:0] idx;
   logic [TAG_W-1:0]   tag;
   logic               unused_addr_bits;

   assign idx = bus.address[INDEX_W+1:2];
   assign tag = bus.address[INDEX_W+TAG_W+1:INDEX_W+2];
   assign unused_addr_bits = ^{bus.address[1:0], bus.address[31:INDEX_W+TAG_W+2]};

   // Lookup.
   logic hit0;
   logic hit1;
   logic hit;

   assign hit0 = valid0[idx] & (tag0_mem[idx] == tag);
   assign hit1 = valid1[idx] & (tag1_mem[idx] == tag);
   assign hit  = hit0 | hit1;

   // Victim for a fill: an invalid way first (way0 before way1), else the LRU way.
   logic fill_way;

   always_comb begin
      fill_way = 1'b0;
      if (!valid0[idx]) begin
         fill_way = 1'b0;
      end else if (!valid1[idx]) begin
         fill_way = 1'b1;
      end else begin
         fill_way = lru[idx];
      end
   end

   // Control outputs of the FSM.
   logic        ready_c;
   logic [31:0] rdata_c;
   logic        rd_en_c;
   logic        wr_en_c;
   logic        rd_hit;    // IDLE read hit this cycle: refresh LRU
   logic        fill_en;   // RMISS completes: allocate the victim way
   logic        wupd_en;   // WRITE completes on a hit: refresh hit way data

   // -------------------------------------------------------------------------
   // FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // FSM: next state and outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      ready_c   = 1'b1;
      rdata_c   = 32'd0;
      rd_en_c   = 1'b0;
      wr_en_c   = 1'b0;
      rd_hit    = 1'b0;
      fill_en   = 1'b0;
      wupd_en   = 1'b0;

      case (state)
         IDLE: begin
            // A store wins over a simultaneous load.
            if (bus.MEM_W_EN) begin
               ready_c   = 1'b0;
               wr_en_c   = 1'b1;
               state_nxt = WRITE;
            end else if (bus.MEM_R_EN) begin
               if (hit) begin
                  rdata_c = hit0 ? data0_mem[idx] : data1_mem[idx];
                  rd_hit  = 1'b1;
               end else begin
                  ready_c   = 1'b0;
                  rd_en_c   = 1'b1;
                  state_nxt = RMISS;
               end
            end
         end

         RMISS: begin
            rd_en_c = 1'b1;
            ready_c = 1'b0;
            if (bus.sram_ready) begin
               ready_c   = 1'b1;
               rdata_c   = bus.sram_rdata;
               fill_en   = 1'b1;
               state_nxt = IDLE;
            end
         end

         WRITE: begin
            wr_en_c = 1'b1;
            ready_c = 1'b0;
            if (bus.sram_ready) begin
               ready_c   = 1'b1;
               // A store withdrawn mid-access only updates SRAM.
               wupd_en   = bus.MEM_W_EN & hit;
               state_nxt = IDLE;
            end
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Valid / LRU bookkeeping
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid0 <= '0;
         valid1 <= '0;
         lru    <= '0;
      end else begin
         if (rd_hit) begin
            // Victim becomes the way that was not hit.
            lru[idx] <= hit0;
         end else if (fill_en) begin
            if (fill_way) begin
               valid1[idx] <= 1'b1;
            end else begin
               valid0[idx] <= 1'b1;
            end
            lru[idx] <= ~fill_way;
         end else if (wupd_en) begin
            lru[idx] <= hit0;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Tag / data arrays
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (fill_en) begin
         if (fill_way) begin
            tag1_mem[idx]  <= tag;
            data1_mem[idx] <= bus.sram_rdata;
         end else begin
            tag0_mem[idx]  <= tag;
            data0_mem[idx] <= bus.sram_rdata;
         end
      end else if (wupd_en) begin
         if (hit0) begin
            data0_mem[idx] <= bus.wdata;
         end else begin
            data1_mem[idx] <= bus.wdata;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Outputs. The enables are gated by reset so an abort drops them in the
   // same cycle even while a request is still presented.
   // -------------------------------------------------------------------------
   assign bus.ready        = ready_c;
   assign bus.rdata        = rdata_c;
   assign bus.sram_rd_en   = rd_en_c & rst;
   assign bus.sram_wr_en   = wr_en_c & rst;
   assign bus.sram_address = bus.address;
   assign bus.sram_wdata   = bus.wdata;
   assign state_dbg        = state;

`ifdef CACHE_STATS_EN
   // -------------------------------------------------------------------------
   // Statistics: hits per IDLE read-hit cycle, misses per IDLE->RMISS move.
   // Both wrap naturally at 2^32.
   // -------------------------------------------------------------------------
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count_q  <= 32'd0;
         miss_count_q <= 32'd0;
      end else begin
         if (rd_hit) begin
            hit_count_q <= hit_count_q + 32'd1;
         end
         if ((state == IDLE) && (state_nxt == RMISS)) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign bus.hit_count  = hit_count_q;
   assign bus.miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// -----------------------------------------------------------------------------
// tb_cache_controller
// Self-checking bench for cache_controller: reset checks, a directed table of
// load/store vectors, a reset-abort sequence, and a randomized phase checked
// against a reference model (per-set recency list of up to two tags plus a
// word-addressed memory image). Compile with +define+CACHE_STATS_EN to also
// check the statistics counters.
// -----------------------------------------------------------------------------
module tb_cache_controller;

   logic       clk;
   logic       rst;
   logic [1:0] state_dbg;

   cache_controller_if bus ();

   cache_controller dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- scoreboard
   int compared;
   int mismatched;
   logic [31:0] exp_q[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      if (got !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- reference model
   // Each set is an ordered list of at most two tags: m_new is the most
   // recently used, m_old the least recently used (the next to be evicted).
   logic [10:0] m_new [64];
   logic [10:0] m_old [64];
   int          m_cnt [64];
   logic [31:0] mem [logic [31:0]];
   int          exp_hits;
   int          exp_miss;

   function automatic int m_set(input logic [31:0] a);
      return int'((a / 4) % 64);
   endfunction

   function automatic logic [10:0] m_tag(input logic [31:0] a);
      return 11'((a / 256) % 2048);
   endfunction

   function automatic bit m_lookup(input logic [31:0] a);
      int s;
      s = m_set(a);
      return (m_cnt[s] >= 1 && m_new[s] == m_tag(a)) || (m_cnt[s] == 2 && m_old[s] == m_tag(a));
   endfunction

   function automatic void m_touch(input logic [31:0] a);
      int s;
      s = m_set(a);
      if (m_cnt[s] == 2 && m_old[s] == m_tag(a)) begin
         m_old[s] = m_new[s];
         m_new[s] = m_tag(a);
      end
   endfunction

   function automatic void m_insert(input logic [31:0] a);
      int s;
      s = m_set(a);
      m_old[s] = m_new[s];
      m_new[s] = m_tag(a);
      if (m_cnt[s] < 2) m_cnt[s]++;
   endfunction

   function automatic void m_clear();
      for (int i = 0; i < 64; i++) begin
         m_cnt[i] = 0;
         m_new[i] = '0;
         m_old[i] = '0;
      end
   endfunction

   // ---------------------------------------------------------------- driver tasks
   task automatic idle_inputs();
      bus.MEM_R_EN   = 1'b0;
      bus.MEM_W_EN   = 1'b0;
      bus.sram_ready = 1'b0;
      bus.sram_rdata = $urandom;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // Load; expected rdata comes from the head of exp_q.
   task automatic do_read(input logic [31:0] a, input bit exp_hit,
                          input logic [31:0] sv, input int dly);
      logic [31:0] e;
      e = exp_q.pop_front();
      @(negedge clk);
      bus.MEM_R_EN = 1'b1;
      bus.address  = a;
      #1;
      check("sram_address", bus.sram_address, a);
      if (exp_hit) begin
         check("rd_hit_ready", 32'(bus.ready), 32'd1);
         check("rd_hit_no_sram_rd", 32'(bus.sram_rd_en), 32'd0);
         check("rd_hit_rdata", bus.rdata, e);
      end else begin
         check("rd_miss_ready", 32'(bus.ready), 32'd0);
         check("rd_miss_sram_rd", 32'(bus.sram_rd_en), 32'd1);
         for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            #1;
            check("rmiss_wait_ready", 32'(bus.ready), 32'd0);
            check("rmiss_wait_sram_rd", 32'(bus.sram_rd_en), 32'd1);
         end
         @(negedge clk);
         bus.sram_ready = 1'b1;
         bus.sram_rdata = sv;
         #1;
         check("rmiss_done_ready", 32'(bus.ready), 32'd1);
         check("rmiss_done_rdata", bus.rdata, e);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input int dly);
      @(negedge clk);
      bus.MEM_W_EN = 1'b1;
      bus.address  = a;
      bus.wdata    = d;
      #1;
      check("wr_ready_low", 32'(bus.ready), 32'd0);
      check("wr_sram_wr", 32'(bus.sram_wr_en), 32'd1);
      check("wr_sram_rd_off", 32'(bus.sram_rd_en), 32'd0);
      check("wr_sram_wdata", bus.sram_wdata, d);
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         #1;
         check("wr_wait_ready", 32'(bus.ready), 32'd0);
         check("wr_wait_sram_wr", 32'(bus.sram_wr_en), 32'd1);
      end
      @(negedge clk);
      bus.sram_ready = 1'b1;
      #1;
      check("wr_done_ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
      idle_inputs();
   endtask

   task automatic check_stats(input string tag_name);
`ifdef CACHE_STATS_EN
      #1;
      check({tag_name, "_hit_count"}, bus.hit_count, 32'(exp_hits));
      check({tag_name, "_miss_count"}, bus.miss_count, 32'(exp_miss));
`else
      if (tag_name.len() == 0) $display("empty stats tag");
`endif
   endtask

   // ---------------------------------------------------------------- directed table
   typedef struct {
      bit          wr;     // 1 = store, 0 = load
      logic [31:0] addr;
      logic [31:0] data;   // store data, or SRAM data returned on a load miss
      int          dly;    // wait cycles before sram_ready
      bit          hit;    // expected load hit
      logic [31:0] exp;    // expected load data
   } vec_t;

   vec_t vt [17];

   // ---------------------------------------------------------------- main
   initial begin
      logic [31:0] a;
      logic [31:0] d;
      int          dly;
      bit          h;

      compared   = 0;
      mismatched = 0;
      exp_hits   = 0;
      exp_miss   = 0;
      m_clear();

      vt[0]  = '{1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 5, 1'b0, 32'hDEAD_BEEF};
      vt[1]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b1, 32'hDEAD_BEEF};
      vt[2]  = '{1'b0, 32'h0000_4100, 32'h4100_4100, 2, 1'b0, 32'h4100_4100};
      vt[3]  = '{1'b0, 32'h0000_4100, 32'h0000_0000, 0, 1'b1, 32'h4100_4100};
      vt[4]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b1, 32'hDEAD_BEEF};
      vt[5]  = '{1'b0, 32'h0000_8100, 32'h8100_8100, 1, 1'b0, 32'h8100_8100};
      vt[6]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b1, 32'hDEAD_BEEF};
      vt[7]  = '{1'b0, 32'h0000_8100, 32'h0000_0000, 0, 1'b1, 32'h8100_8100};
      vt[8]  = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b1, 32'hDEAD_BEEF};
      vt[9]  = '{1'b0, 32'h0000_4100, 32'h4100_4100, 0, 1'b0, 32'h4100_4100};
      vt[10] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 3, 1'b0, 32'h0000_0000};
      vt[11] = '{1'b0, 32'h0000_0100, 32'h0000_0000, 0, 1'b1, 32'h1234_5678};
      vt[12] = '{1'b0, 32'h0000_8100, 32'h8100_8100, 2, 1'b0, 32'h8100_8100};
      vt[13] = '{1'b1, 32'h0000_0200, 32'hCAFE_0200, 1, 1'b0, 32'h0000_0000};
      vt[14] = '{1'b0, 32'h0000_0200, 32'hCAFE_0200, 0, 1'b0, 32'hCAFE_0200};
      vt[15] = '{1'b0, 32'h0000_0200, 32'h0000_0000, 0, 1'b1, 32'hCAFE_0200};
      vt[16] = '{1'b0, 32'h0000_0100, 32'h1234_5678, 1, 1'b0, 32'h1234_5678};

      // ---- reset state
      rst         = 1'b0;
      bus.address = 32'd0;
      bus.wdata   = 32'd0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      check("rst_ready", 32'(bus.ready), 32'd1);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_sram_rd", 32'(bus.sram_rd_en), 32'd0);
      check("rst_sram_wr", 32'(bus.sram_wr_en), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check_stats("rst");
      @(negedge clk);
      rst = 1'b1;

      // ---- sram_ready pulse in IDLE is ignored
      @(negedge clk);
      bus.sram_ready = 1'b1;
      bus.sram_rdata = 32'h5555_AAAA;
      #1;
      check("idle_pulse_ready", 32'(bus.ready), 32'd1);
      check("idle_pulse_rdata", bus.rdata, 32'd0);
      @(negedge clk);
      bus.sram_ready = 1'b0;
      #1;
      check("idle_pulse_state", 32'(state_dbg), 32'd0);

      // ---- directed table
      for (int i = 0; i < 17; i++) begin
         if (vt[i].wr) begin
            do_write(vt[i].addr, vt[i].data, vt[i].dly);
         end else begin
            exp_q.push_back(vt[i].exp);
            if (vt[i].hit) exp_hits++;
            else exp_miss++;
            do_read(vt[i].addr, vt[i].hit, vt[i].data, vt[i].dly);
         end
      end
      check_stats("table");

      // ---- reset in the middle of a read miss
      @(negedge clk);
      bus.MEM_R_EN = 1'b1;
      bus.address  = 32'h0000_0300;
      @(negedge clk);
      #1;
      check("abort_pre_sram_rd", 32'(bus.sram_rd_en), 32'd1);
      check("abort_pre_state", 32'(state_dbg), 32'd1);
      rst = 1'b0;
      #1;
      check("abort_sram_rd_drop", 32'(bus.sram_rd_en), 32'd0);
      check("abort_sram_wr_drop", 32'(bus.sram_wr_en), 32'd0);
      check("abort_state", 32'(state_dbg), 32'd0);
      idle_inputs();
      #1;
      check("abort_idle_ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      exp_hits = 0;
      exp_miss = 1;
      exp_q.push_back(32'h1234_5678);
      do_read(32'h0000_0100, 1'b0, 32'h1234_5678, 2);
      check_stats("abort");

      // ---- store and load together: treated as a store
      @(negedge clk);
      bus.MEM_R_EN = 1'b1;
      bus.MEM_W_EN = 1'b1;
      bus.address  = 32'h0000_0100;
      bus.wdata    = 32'h0BAD_F00D;
      #1;
      check("rw_sram_wr", 32'(bus.sram_wr_en), 32'd1);
      check("rw_sram_rd", 32'(bus.sram_rd_en), 32'd0);
      @(negedge clk);
      bus.sram_ready = 1'b1;
      #1;
      check("rw_done_ready", 32'(bus.ready), 32'd1);
      @(negedge clk);
      idle_inputs();
      exp_q.push_back(32'h0BAD_F00D);
      do_read(32'h0000_0100, 1'b1, 32'd0, 0);

      // ---- randomized phase against the reference model
      do_reset();
      m_clear();
      mem.delete();
      exp_hits = 0;
      exp_miss = 0;
      for (int n = 0; n < 400; n++) begin
         a   = (32'($urandom_range(0, 3)) * 256) + (32'($urandom_range(0, 1)) * 4);
         dly = int'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            d = $urandom;
            if (m_lookup(a)) m_touch(a);
            mem[a] = d;
            do_write(a, d, dly);
         end else begin
            if (!mem.exists(a)) mem[a] = $urandom;
            h = m_lookup(a);
            if (h) begin
               m_touch(a);
               exp_hits++;
            end else begin
               m_insert(a);
               exp_miss++;
            end
            exp_q.push_back(mem[a]);
            do_read(a, h, mem[a], dly);
         end
      end
      check_stats("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
